// File: rtl/echo_enq_arbiter.sv
// Round-robin arbiter that shares one Echo fifoenq method among NREQ requesters,
// with a bounded burst per grant and a one-entry output register toward the Echo.
module echo_enq_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int IDW       = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREQ-1:0]        req_want,
    input  logic [NREQ-1:0]        req_enq__ENA,
    input  logic [NREQ*DATA_W-1:0] req_enq_v,
    output logic [NREQ-1:0]        req_enq__RDY,
    output logic                   fifoenq__ENA,
    output logic [DATA_W-1:0]      fifoenq_v,
    input  logic                   fifoenq__RDY,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   protocol_err
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int CW = IDW + 1;

    state_t          state, state_nxt;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [3:0]      beat_cnt, beat_nxt;
    logic            out_valid;
    logic [DATA_W-1:0] out_data;

    logic            slot_free;
    logic            accept;
    logic            last_beat;
    logic            ena_bad;
    logic            found;
    logic [IDW-1:0]  pick;
    logic [CW-1:0]   cand;
    logic [IDW-1:0]  owner_inc;
    logic [DATA_W-1:0] req_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign req_data[g] = req_enq_v[g*DATA_W +: DATA_W];
    end

    // Refill is allowed in the same cycle the Echo drains the held entry.
    assign slot_free    = !out_valid || fifoenq__RDY;
    assign req_enq__RDY = (state == GRANT && slot_free) ? (NREQ'(1) << owner) : '0;
    assign accept       = req_enq__ENA[owner] && req_enq__RDY[owner];
    assign last_beat    = (beat_cnt + 4'd1) == 4'(MAX_BURST);
    assign ena_bad      = |(req_enq__ENA & ~req_enq__RDY);
    assign owner_inc    = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);

    assign fifoenq__ENA = out_valid && fifoenq__RDY;
    assign fifoenq_v    = out_data;
    assign grant_id     = owner;
    assign busy         = (state == GRANT);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latches are inferred.
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        beat_nxt   = beat_cnt;
        found      = 1'b0;
        pick       = rr_ptr;
        cand       = '0;

        // First wanting index at or above rr_ptr, wrapping modulo NREQ.
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (!found && req_want[cand[IDW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDW-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = pick;
                    beat_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (accept) beat_nxt = beat_cnt + 4'd1;
                if ((accept && last_beat) || (!req_want[owner] && !accept)) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            beat_cnt     <= '0;
            out_valid    <= 1'b0;
            // NOTE: the data register is reset too, since fifoenq_v must read 0 during reset.
            out_data     <= '0;
            protocol_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_nxt;
            if (accept) begin
                out_data  <= req_data[owner];
                out_valid <= 1'b1;
            end else if (fifoenq__ENA) begin
                out_valid <= 1'b0;
            end
            if (ena_bad) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_echo_enq_arbiter.sv
// Randomized and directed bench for echo_enq_arbiter against a transaction-level
// reference model (grant rules plus a queue scoreboard for the output register).
module tb_echo_enq_arbiter;

    localparam int NREQ      = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic [NREQ-1:0]        req_want;
    logic [NREQ-1:0]        req_enq__ENA;
    logic [NREQ*DATA_W-1:0] req_enq_v;
    logic [NREQ-1:0]        req_enq__RDY;
    logic                   fifoenq__ENA;
    logic [DATA_W-1:0]      fifoenq_v;
    logic                   fifoenq__RDY;
    logic [IDW-1:0]         grant_id;
    logic                   busy;
    logic                   protocol_err;

    echo_enq_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .IDW(IDW)) dut (
        .CLK(CLK), .nRST(nRST), .req_want(req_want), .req_enq__ENA(req_enq__ENA),
        .req_enq_v(req_enq_v), .req_enq__RDY(req_enq__RDY), .fifoenq__ENA(fifoenq__ENA),
        .fifoenq_v(fifoenq_v), .fifoenq__RDY(fifoenq__RDY), .grant_id(grant_id),
        .busy(busy), .protocol_err(protocol_err)
    );

    always #5 CLK = ~CLK;

    int assertions = 0;
    int failures   = 0;

    // Reference model: who owns the port, how many beats taken, where the pointer is,
    // and what the Echo should receive next.
    bit                m_grant;
    int                m_owner;
    int                m_beats;
    int                m_ptr;
    bit                m_perr;
    logic [DATA_W-1:0] m_q[$];
    bit                last_acc;

    function automatic int pick_next(input logic [NREQ-1:0] want, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx = (ptr + k) % NREQ;
            if (want[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_grant = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_perr = 0;
        m_q.delete();
    endtask

    task automatic do_reset();
        req_want = '0; req_enq__ENA = '0; req_enq_v = '0; fifoenq__RDY = 1'b0;
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic run_cycle(input logic [NREQ-1:0] want, input logic [NREQ-1:0] ena_pick,
                             input logic [NREQ-1:0] ena_force, input bit frdy,
                             input bit rand_val, input logic [DATA_W-1:0] val);
        logic [NREQ-1:0]   exp_rdy, ena;
        logic [DATA_W-1:0] vals [NREQ];
        bit                exp_fena, acc;
        exp_fena = (m_q.size() != 0) && frdy;
        exp_rdy  = (m_grant && (m_q.size() == 0 || frdy)) ? (NREQ'(1) << m_owner) : '0;
        ena      = (ena_pick & exp_rdy) | ena_force;
        for (int i = 0; i < NREQ; i++) begin
            vals[i] = rand_val ? DATA_W'($urandom) : ((i == m_owner) ? val : ~val);
            req_enq_v[i*DATA_W +: DATA_W] = vals[i];
        end
        req_want = want; req_enq__ENA = ena; fifoenq__RDY = frdy;
        @(negedge CLK);
        assertions++;
        if (req_enq__RDY !== exp_rdy) begin
            failures++; $display("FAIL rdy t=%0t: got %b expected %b", $time, req_enq__RDY, exp_rdy);
        end
        assertions++;
        if (fifoenq__ENA !== exp_fena) begin
            failures++; $display("FAIL fifoenq_ena t=%0t: got %b expected %b", $time, fifoenq__ENA, exp_fena);
        end
        if (exp_fena) begin
            assertions++;
            if (fifoenq_v !== m_q[0]) begin
                failures++; $display("FAIL fifoenq_v t=%0t: got %h expected %h", $time, fifoenq_v, m_q[0]);
            end
        end
        assertions++;
        if (busy !== m_grant) begin
            failures++; $display("FAIL busy t=%0t: got %b expected %b", $time, busy, m_grant);
        end
        assertions++;
        if (grant_id !== IDW'(m_owner)) begin
            failures++; $display("FAIL grant_id t=%0t: got %0d expected %0d", $time, grant_id, m_owner);
        end
        assertions++;
        if (protocol_err !== m_perr) begin
            failures++; $display("FAIL protocol_err t=%0t: got %b expected %b", $time, protocol_err, m_perr);
        end
        last_acc = |(req_enq__RDY & req_enq__ENA);

        acc = |(ena & exp_rdy);
        if ((ena & ~exp_rdy) != '0) m_perr = 1;
        if (exp_fena) void'(m_q.pop_front());
        if (acc) m_q.push_back(vals[m_owner]);
        if (!m_grant) begin
            int p = pick_next(want, m_ptr);
            if (p >= 0) begin m_grant = 1; m_owner = p; m_beats = 0; end
        end else begin
            if (acc) m_beats++;
            if ((acc && m_beats == MAX_BURST) || (!want[m_owner] && !acc)) begin
                m_grant = 0;
                m_ptr   = (m_owner + 1) % NREQ;
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        req_want = '0; req_enq__ENA = '0; req_enq_v = '0; fifoenq__RDY = 1'b1;
        nRST = 1'b0;
        #3;
        assertions++;
        if ({req_enq__RDY, fifoenq__ENA, fifoenq_v, grant_id, busy, protocol_err} !== '0) begin
            failures++; $display("FAIL reset_initial: got rdy=%b ena=%b v=%h id=%0d busy=%b perr=%b expected all 0",
                                 req_enq__RDY, fifoenq__ENA, fifoenq_v, grant_id, busy, protocol_err);
        end
        do_reset();
        run_cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h5A5A_0001);
        run_cycle(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h5A5A_0002);
        fifoenq__RDY = 1'b1;
        #1;
        assertions++;
        if (fifoenq__ENA !== 1'b1) begin
            failures++; $display("FAIL reset_pre_held: got ena=%b expected 1", fifoenq__ENA);
        end
        #1 nRST = 1'b0;
        #1;
        assertions++;
        if ({req_enq__RDY, fifoenq__ENA, fifoenq_v, grant_id, busy, protocol_err} !== '0) begin
            failures++; $display("FAIL reset_async: got rdy=%b ena=%b v=%h id=%0d busy=%b perr=%b expected all 0",
                                 req_enq__RDY, fifoenq__ENA, fifoenq_v, grant_id, busy, protocol_err);
        end
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) run_cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, '0);
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            run_cycle(4'b0010, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'd22);
            if (c == 4) begin
                assertions++;
                if (busy !== 1'b0) begin
                    failures++; $display("FAIL single_burst_end: got busy=%b expected 0", busy);
                end
            end
        end
        assertions++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            failures++; $display("FAIL single_regrant: got busy=%b id=%0d expected busy=1 id=1", busy, grant_id);
        end
        for (int c = 0; c < 3; c++) run_cycle(4'b0010, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'd22);
    endtask

    task automatic test_round_robin();
        int owners[$];
        int accs[8];
        int gnum = -1;
        bit was_busy = 0;
        do_reset();
        for (int c = 0; c < 23; c++) begin
            run_cycle(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, '0);
            if (gnum >= 0 && gnum < 8 && last_acc) accs[gnum]++;
            if (busy && !was_busy) begin
                gnum++;
                owners.push_back(int'(grant_id));
                if (gnum < 8) accs[gnum] = 0;
            end
            was_busy = busy;
        end
        assertions++;
        if (owners.size() < 5) begin
            failures++; $display("FAIL rr_grant_count: got %0d expected >=5", owners.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
                assertions++;
                if (owners[g] != (g % NREQ)) begin
                    failures++; $display("FAIL rr_order[%0d]: got %0d expected %0d", g, owners[g], g % NREQ);
                end
            end
            for (int g = 0; g < 4; g++) begin
                assertions++;
                if (accs[g] != MAX_BURST) begin
                    failures++; $display("FAIL rr_beats[%0d]: got %0d expected %0d", g, accs[g], MAX_BURST);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_cycle(4'b0100, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0000_0200);
        run_cycle(4'b0100, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0000_0201);
        run_cycle(4'b0100, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0000_0202);
        for (int c = 0; c < 5; c++) begin
            run_cycle(4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0000_0EEE);
            assertions++;
            if (fifoenq_v !== 32'h0000_0202 || busy !== 1'b1 || grant_id !== 2'd2) begin
                failures++; $display("FAIL bp_hold: got v=%h busy=%b id=%0d expected v=00000202 busy=1 id=2",
                                     fifoenq_v, busy, grant_id);
            end
        end
        for (int c = 0; c < 6; c++)
            run_cycle(4'b0100, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0000_0203 + DATA_W'(c));
    endtask

    task automatic test_early_release();
        do_reset();
        run_cycle(4'b1000, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0000_0300);
        run_cycle(4'b1000, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0000_0301);
        run_cycle(4'b1000, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0000_0302);
        run_cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0303);
        assertions++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL early_idle: got busy=%b expected 0", busy);
        end
        run_cycle(4'b0110, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0304);
        assertions++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            failures++; $display("FAIL early_next_owner: got busy=%b id=%0d expected busy=1 id=1", busy, grant_id);
        end
        for (int c = 0; c < 3; c++) run_cycle(4'b0110, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0000_0310);
    endtask

    task automatic test_protocol_err();
        do_reset();
        run_cycle(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0400);
        run_cycle(4'b0001, 4'b0001, 4'b0010, 1'b1, 1'b0, 32'h0000_0401);
        assertions++;
        if (protocol_err !== 1'b1) begin
            failures++; $display("FAIL perr_set: got %b expected 1", protocol_err);
        end
        for (int c = 0; c < 4; c++) run_cycle(4'b0001, 4'b0000, 4'b0010, 1'b1, 1'b0, 32'h0000_0402);
        for (int c = 0; c < 4; c++) run_cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0403);
        assertions++;
        if (protocol_err !== 1'b1) begin
            failures++; $display("FAIL perr_sticky: got %b expected 1", protocol_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++)
            run_cycle(NREQ'($urandom), NREQ'($urandom), 4'b0000, ($urandom_range(0, 3) != 0), 1'b1, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_protocol_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
